axi_read_scheduler: RTL and testbench

Sequencer and arbiter in front of `axi_read_block`. It accepts byte-sized read requests from two requesters and arbitrates between them round-robin. Each accepted request is split into chunks of at most `MAX_CHUNK` bytes, and each chunk is issued to the read block as one start/done transaction. Each requester receives a single done pulse when its whole request has been transferred.

---
 rtl/axi_rd_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/axi_read_scheduler.sv | 144 ++++++++++++++
 tb/tb_axi_read_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared definitions for the AXI read scheduler: FSM state encoding,
// default chunk limit and the 4 KB page size used by the optional
// boundary split (enabled with AXI_RD_SCHED_4K_SPLIT_EN).
package axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_MAX_CHUNK = 64;
  localparam int BOUNDARY_4K       = 4096;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. The priority pointer only matters when
// both inputs request; it moves to the other requester when update is high.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset_n,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_update,
  input  logic i_served,
  output logic o_grant_valid,
  output logic o_grant
);

  logic r_ptr;

  // Priority pointer: after serving a requester, favour the other one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= 1'b0;
    end else if (i_update) begin
      r_ptr <= ~i_served;
    end
  end

  // Grant: pointer holder wins a tie, a lone requester always wins.
  always_comb begin
    o_grant_valid = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_grant = r_ptr;
    end else if (i_req1) begin
      o_grant = 1'b1;
    end else begin
      o_grant = 1'b0;
    end
  end

endmodule

// File: rtl/axi_read_scheduler.sv
// Arbitrates two byte-sized read requesters and splits each accepted
// request into read-block transactions of at most MAX_CHUNK bytes.
// Optional macro AXI_RD_SCHED_4K_SPLIT_EN: chunks never cross 4 KB.
module axi_read_scheduler
  import axi_rd_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_CHUNK = DEFAULT_MAX_CHUNK
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_size,
  output logic              req0_ready,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_size,
  output logic              req1_ready,
  output logic              req1_done,
  output logic              blk_start,
  output logic [ADDR_W-1:0] blk_addr,
  output logic [LEN_W-1:0]  blk_transfer_size,
  input  logic              blk_busy,
  input  logic              blk_done,
  output logic              sched_busy
);

  localparam logic [LEN_W-1:0]  C_MAX_CHUNK  = LEN_W'(MAX_CHUNK);
  localparam logic [LEN_W-1:0]  C_SIZE_MASK  = ~LEN_W'(3);
  localparam logic [ADDR_W-1:0] C_ADDR_MASK  = ~ADDR_W'(3);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_owner;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [LEN_W-1:0]  r_remaining;

  logic              w_grant_valid;
  logic              w_grant;
  logic              w_accept;
  logic              w_start;
  logic              w_done_pulse;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LEN_W-1:0]  w_sel_size;
  logic [LEN_W-1:0]  w_chunk_base;
  logic [LEN_W-1:0]  w_chunk;
  logic [LEN_W-1:0]  w_rem_after;

  rr_arbiter2 u_arb (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_req0        (req0_valid),
    .i_req1        (req1_valid),
    .i_update      (w_done_pulse),
    .i_served      (r_owner),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant)
  );

  // Request of the granted requester, word-aligned.
  assign w_sel_addr = (w_grant ? req1_addr : req0_addr) & C_ADDR_MASK;
  assign w_sel_size = (w_grant ? req1_size : req0_size) & C_SIZE_MASK;

  // Chunk size: remaining bytes capped at MAX_CHUNK (and optionally the page end).
  assign w_chunk_base = (r_remaining < C_MAX_CHUNK) ? r_remaining : C_MAX_CHUNK;
`ifdef AXI_RD_SCHED_4K_SPLIT_EN
  logic [12:0] w_to_4k;
  assign w_to_4k = 13'(BOUNDARY_4K) - {1'b0, r_cur_addr[11:0]};
  assign w_chunk = (LEN_W'(w_to_4k) < w_chunk_base) ? LEN_W'(w_to_4k) : w_chunk_base;
`else
  assign w_chunk = w_chunk_base;
`endif
  assign w_rem_after = r_remaining - w_chunk;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and strobes; accept is suppressed while reset is asserted.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_start      = 1'b0;
    w_done_pulse = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid && reset_n) begin
          w_accept     = 1'b1;
          w_state_next = (w_sel_size == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!blk_busy) begin
          w_start      = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (blk_done) begin
          w_state_next = (w_rem_after == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        w_done_pulse = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request context: latched on accept, advanced by one chunk per blk_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= 1'b0;
      r_cur_addr  <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_owner     <= w_grant;
      r_cur_addr  <= w_sel_addr;
      r_remaining <= w_sel_size;
    end else if (r_state == ST_WAIT && blk_done) begin
      r_cur_addr  <= r_cur_addr + ADDR_W'(w_chunk);
      r_remaining <= w_rem_after;
    end
  end

  assign req0_ready        = w_accept & ~w_grant;
  assign req1_ready        = w_accept & w_grant;
  assign req0_done         = w_done_pulse & ~r_owner;
  assign req1_done         = w_done_pulse & r_owner;
  assign blk_start         = w_start;
  assign blk_addr          = r_cur_addr;
  assign blk_transfer_size = w_chunk;
  assign sched_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi_read_scheduler.sv
// Self-checking bench for axi_read_scheduler: transaction-level model of
// arbitration, chunking and event timing, checked every cycle, plus
// directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_axi_read_scheduler;
  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 16;
  localparam int MAX_CHUNK = 64;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
  logic [LEN_W-1:0]  req0_size = '0, req1_size = '0;
  logic              req0_ready, req1_ready, req0_done, req1_done;
  logic              blk_start, sched_busy;
  logic [ADDR_W-1:0] blk_addr;
  logic [LEN_W-1:0]  blk_transfer_size;
  logic              blk_busy = 1'b0, blk_done = 1'b0;

  always #5 clk = ~clk;

  axi_read_scheduler #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_CHUNK(MAX_CHUNK)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_size(req0_size),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_size(req1_size),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .blk_start(blk_start), .blk_addr(blk_addr), .blk_transfer_size(blk_transfer_size),
    .blk_busy(blk_busy), .blk_done(blk_done), .sched_busy(sched_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Pending drive values, applied just after the next rising edge
  bit          nxt_rst = 1'b0;
  bit          nxt_v0 = 1'b0, nxt_v1 = 1'b0;
  logic [31:0] nxt_a0 = '0, nxt_a1 = '0;
  logic [15:0] nxt_s0 = '0, nxt_s1 = '0;
  bit          rand_mode = 1'b0;
  int          busy_force = 0;
  bit          em_out = 1'b0;
  int          em_cnt = 0;

  // Behavioural model
  bit          m_active = 1'b0, m_owner = 1'b0, m_ptr = 1'b0, m_inflight = 1'b0;
  int          m_idle_from = 0, m_grant_cyc = 0, m_start_from = 0, m_done_due = -1;
  logic [31:0] m_fly_addr = '0;
  logic [15:0] m_fly_size = '0;
  logic [31:0] q_addr[$];
  logic [15:0] q_size[$];

  // Logs of observed DUT behaviour for literal checks
  int          grant_log[$];
  logic [31:0] slog_addr[$];
  logic [15:0] slog_size[$];
  int          last_ready_cyc = 0, last_start_cyc = 0, last_done_cyc = 0, last_bdone_cyc = 0;
  int          done_cnt0 = 0, done_cnt1 = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endfunction

  // Chunk list of a request, straight from the splitting rules
  function automatic void build_chunks(input logic [31:0] addr, input logic [15:0] size);
    longint a;
    int     r;
    int     c;
    a = longint'(addr & 32'hFFFF_FFFC);
    r = int'(size & 16'hFFFC);
    q_addr.delete();
    q_size.delete();
    while (r > 0) begin
      c = (r < MAX_CHUNK) ? r : MAX_CHUNK;
`ifdef AXI_RD_SCHED_4K_SPLIT_EN
      if (4096 - int'(a % 4096) < c) c = 4096 - int'(a % 4096);
`endif
      q_addr.push_back(a[31:0]);
      q_size.push_back(c[15:0]);
      a = (a + c) % 64'h1_0000_0000;
      r = r - c;
    end
  endfunction

  function automatic void model_reset();
    m_active    = 1'b0;
    m_ptr       = 1'b0;
    m_inflight  = 1'b0;
    m_idle_from = cyc;
    m_done_due  = -1;
    q_addr.delete();
    q_size.delete();
    em_out      = 1'b0;
  endfunction

  function automatic void check_cycle();
    bit e_r0, e_r1, e_start, e_d0, e_d1, e_busy, g;
    if (!reset_n) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_done0", req0_done, 0);
      chk("rst_done1", req1_done, 0);
      chk("rst_start", blk_start, 0);
      chk("rst_busy", sched_busy, 0);
      chk("rst_addr", blk_addr, 0);
      chk("rst_size", blk_transfer_size, 0);
      model_reset();
      return;
    end
    e_r0 = 1'b0; e_r1 = 1'b0; g = 1'b0;
    if (!m_active && cyc >= m_idle_from && (req0_valid || req1_valid)) begin
      g    = (req0_valid && req1_valid) ? m_ptr : (req1_valid && !req0_valid);
      e_r0 = !g;
      e_r1 = g;
    end
    e_start = m_active && !m_inflight && q_addr.size() > 0 && cyc >= m_start_from && !blk_busy;
    e_d0    = m_active && cyc == m_done_due && !m_owner;
    e_d1    = m_active && cyc == m_done_due && m_owner;
    e_busy  = m_active && cyc > m_grant_cyc;

    chk("ready0", req0_ready, e_r0);
    chk("ready1", req1_ready, e_r1);
    chk("start", blk_start, e_start);
    chk("done0", req0_done, e_d0);
    chk("done1", req1_done, e_d1);
    chk("sched_busy", sched_busy, e_busy);
    if (e_start) begin
      chk("start_addr", blk_addr, q_addr[0]);
      chk("start_size", blk_transfer_size, q_size[0]);
    end else if (m_inflight) begin
      chk("hold_addr", blk_addr, m_fly_addr);
      chk("hold_size", blk_transfer_size, m_fly_size);
    end

    // Observations driving the stimulus side and the logs
    if (req0_ready) nxt_v0 = 1'b0;
    if (req1_ready) nxt_v1 = 1'b0;
    if (req0_ready || req1_ready) begin
      grant_log.push_back(req1_ready ? 1 : 0);
      last_ready_cyc = cyc;
    end
    if (blk_start) begin
      slog_addr.push_back(blk_addr);
      slog_size.push_back(blk_transfer_size);
      last_start_cyc = cyc;
      em_out = 1'b1;
      em_cnt = $urandom_range(4, 1);
    end
    if (req0_done || req1_done) begin
      last_done_cyc = cyc;
      if (req0_done) done_cnt0++;
      if (req1_done) done_cnt1++;
      $display("[TB] cyc=%0d request done owner=%0d", cyc, req1_done ? 1 : 0);
    end

    // Model advance
    if (e_d0 || e_d1) begin
      m_active    = 1'b0;
      m_ptr       = !m_owner;
      m_idle_from = cyc + 1;
    end
    if (m_inflight && blk_done) begin
      m_inflight = 1'b0;
      if (q_addr.size() == 0) m_done_due = cyc + 1;
      else m_start_from = cyc + 1;
    end
    if (e_start) begin
      m_fly_addr = q_addr.pop_front();
      m_fly_size = q_size.pop_front();
      m_inflight = 1'b1;
    end
    if (e_r0 || e_r1) begin
      m_active    = 1'b1;
      m_owner     = g;
      m_grant_cyc = cyc;
      build_chunks(g ? req1_addr : req0_addr, g ? req1_size : req0_size);
      if (q_addr.size() == 0) m_done_due = cyc + 1;
      else begin
        m_start_from = cyc + 1;
        m_done_due   = -1;
      end
    end
  endfunction

  function automatic void gen_requests();
    logic [31:0] a;
    if (!nxt_v0 && !req0_valid && $urandom_range(5) == 0) begin
      a = $urandom();
      if ($urandom_range(1) == 1) a[11:0] = 12'hF00 + 12'($urandom_range(255));
      nxt_v0 = 1'b1; nxt_a0 = a; nxt_s0 = 16'($urandom_range(300));
    end
    if (!nxt_v1 && !req1_valid && $urandom_range(5) == 0) begin
      a = $urandom();
      if ($urandom_range(1) == 1) a[11:0] = 12'hF00 + 12'($urandom_range(255));
      nxt_v1 = 1'b1; nxt_a1 = a; nxt_s1 = 16'($urandom_range(300));
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rand_mode) gen_requests();
    reset_n    = nxt_rst;
    req0_valid = nxt_v0; req0_addr = nxt_a0; req0_size = nxt_s0;
    req1_valid = nxt_v1; req1_addr = nxt_a1; req1_size = nxt_s1;
    blk_done = 1'b0;
    if (em_out) begin
      em_cnt--;
      if (em_cnt == 0) begin
        blk_done = 1'b1;
        em_out   = 1'b0;
        last_bdone_cyc = cyc;
      end
    end else if (rand_mode && $urandom_range(15) == 0) begin
      blk_done = 1'b1;
    end
    if (busy_force > 0) begin
      blk_busy = 1'b1;
      busy_force--;
    end else begin
      blk_busy = rand_mode ? ($urandom_range(3) == 0) : 1'b0;
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_until_quiet(input int max_cycles);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((m_active || nxt_v0 || nxt_v1 || req0_valid || req1_valid) && n < max_cycles);
    if (n >= max_cycles) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout cyc=%0d actual=busy required=idle within %0d cycles", cyc, max_cycles);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    slog_addr.delete();
    slog_size.delete();
    done_cnt0 = 0;
    done_cnt1 = 0;
  endtask

  initial begin
    int n;
    // Pin the chunking model to hand-computed splits
    build_chunks(32'h0, 16'd200);
    chk("pin_split_n", q_addr.size(), 4);
    chk("pin_split_a3", q_addr[3], 32'hC0);
    chk("pin_split_s3", q_size[3], 8);
    build_chunks(32'hFF0, 16'd64);
`ifdef AXI_RD_SCHED_4K_SPLIT_EN
    chk("pin_4k_n", q_addr.size(), 2);
    chk("pin_4k_s0", q_size[0], 16);
`else
    chk("pin_4k_n", q_addr.size(), 1);
    chk("pin_4k_s0", q_size[0], 64);
`endif
    q_addr.delete();
    q_size.delete();

    // Reset, then release
    nxt_rst = 1'b0;
    repeat (3) step();
    nxt_rst = 1'b1;
    step();

    // Simultaneous pair after reset: req0 first (single chunk), then req1 (split)
    clear_logs();
    nxt_v0 = 1'b1; nxt_a0 = 32'h100; nxt_s0 = 16'd16;
    nxt_v1 = 1'b1; nxt_a1 = 32'h0;   nxt_s1 = 16'd200;
    run_until_quiet(400);
    chk("rr_first", grant_log.size() > 0 ? grant_log[0] : 9, 0);
    chk("rr_second", grant_log.size() > 1 ? grant_log[1] : 9, 1);
    chk("n_starts", slog_addr.size(), 5);
    chk("single_addr", slog_addr[0], 32'h100);
    chk("single_size", slog_size[0], 16);
    chk("split_a1", slog_addr[2], 32'h40);
    chk("split_a3", slog_addr[4], 32'hC0);
    chk("split_s3", slog_size[4], 8);
    chk("done_cnt0", done_cnt0, 1);
    chk("done_cnt1", done_cnt1, 1);

    // Unaligned address, lone requester
    clear_logs();
    nxt_v0 = 1'b1; nxt_a0 = 32'h102; nxt_s0 = 16'd8;
    run_until_quiet(100);
    chk("unal_addr", slog_addr[0], 32'h100);
    chk("unal_size", slog_size[0], 8);
    chk("last_done_lat", last_done_cyc - last_bdone_cyc, 1);

    // Degenerate sizes, simultaneous: pointer now favours req1
    clear_logs();
    nxt_v0 = 1'b1; nxt_a0 = 32'h40; nxt_s0 = 16'd0;
    nxt_v1 = 1'b1; nxt_a1 = 32'h80; nxt_s1 = 16'd3;
    run_until_quiet(100);
    chk("rr_swap_first", grant_log.size() > 0 ? grant_log[0] : 9, 1);
    chk("zero_no_start", slog_addr.size(), 0);
    chk("zero_done_lat", last_done_cyc - last_ready_cyc, 1);

    // 4 KB boundary
    clear_logs();
    nxt_v0 = 1'b1; nxt_a0 = 32'hFF0; nxt_s0 = 16'd64;
    run_until_quiet(100);
`ifdef AXI_RD_SCHED_4K_SPLIT_EN
    chk("4k_n", slog_addr.size(), 2);
    chk("4k_a1", slog_addr[1], 32'h1000);
    chk("4k_s1", slog_size[1], 48);
`else
    chk("4k_n", slog_addr.size(), 1);
    chk("4k_s0", slog_size[0], 64);
`endif

    // Backpressure: busy high through five ISSUE cycles
    clear_logs();
    nxt_v0 = 1'b1; nxt_a0 = 32'h200; nxt_s0 = 16'd16;
    busy_force = 6;
    run_until_quiet(100);
    chk("bp_delay", last_start_cyc - last_ready_cyc, 6);

    // Reset during WAIT, then a pair must be served from requester 0
    nxt_v0 = 1'b1; nxt_a0 = 32'h0; nxt_s0 = 16'd200;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_inflight && n < 20);
    chk("reach_wait", m_inflight, 1);
    nxt_rst = 1'b0;
    step();
    step();
    nxt_rst = 1'b1;
    step();
    clear_logs();
    nxt_v0 = 1'b1; nxt_a0 = 32'h300; nxt_s0 = 16'd4;
    nxt_v1 = 1'b1; nxt_a1 = 32'h400; nxt_s1 = 16'd4;
    run_until_quiet(100);
    chk("post_rst_first", grant_log.size() > 0 ? grant_log[0] : 9, 0);

    // Randomized traffic
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    run_until_quiet(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
